// File: rtl/lfsr_pkg.sv
// Shared definitions for the team's 8-bit XNOR LFSR generator and its stream checker.
// Both ends take their feedback from lfsr_next_bit so the two cannot drift apart.
package lfsr_pkg;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_TAP_HI = 7;
    localparam int unsigned DEF_TAP_LO = 3;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lfsr_state_e;

    // XNOR feedback: all-zeros is a legal start state, all-ones is the lockup state.
    function automatic logic lfsr_next_bit(input logic [31:0]   lfsr_reg,
                                           input int unsigned   tap_hi,
                                           input int unsigned   tap_lo);
        return ~(lfsr_reg[tap_hi[4:0]] ^ lfsr_reg[tap_lo[4:0]]);
    endfunction

endpackage

// File: rtl/lfsr_err_window.sv
// Sliding error budget for the locked checker: counts mismatches per window of compared
// bits and flags the mismatch that exhausts the budget.
module lfsr_err_window #(
    parameter int unsigned ERR_LIMIT  = 4,
    parameter int unsigned ERR_WINDOW = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic step_i,
    input  logic mismatch_i,
    input  logic clear_i,
    output logic limit_hit_o
);

    localparam int unsigned POS_W = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int unsigned ERR_W = $clog2(ERR_LIMIT + 1);

    logic [POS_W-1:0] win_pos_q, win_pos_d;
    logic [ERR_W-1:0] win_err_q, win_err_d;
    logic             last_bit;

    assign last_bit    = (win_pos_q == POS_W'(ERR_WINDOW - 1));
    // A mismatch on the last window bit still counts against the closing window.
    assign limit_hit_o = step_i & mismatch_i & (win_err_q == ERR_W'(ERR_LIMIT - 1));

    always_comb begin
        win_pos_d = win_pos_q;
        win_err_d = win_err_q;
        if (clear_i) begin
            win_pos_d = '0;
            win_err_d = '0;
        end else if (step_i) begin
            win_pos_d = last_bit ? '0 : win_pos_q + 1'b1;
            if (last_bit)        win_err_d = '0;
            else if (mismatch_i) win_err_d = win_err_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            win_pos_q <= '0;
            win_err_q <= '0;
        end else begin
            win_pos_q <= win_pos_d;
            win_err_q <= win_err_d;
        end
    end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the XNOR LFSR stream: fills a shadow register, verifies it, then
// flywheels on its own prediction and flags mismatches. Stats counters: `LFSR_CHK_STATS_EN.
module lfsr_stream_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned TAP_HI     = DEF_TAP_HI,
    parameter int unsigned TAP_LO     = DEF_TAP_LO,
    parameter int unsigned LOCK_COUNT = 16,
    parameter int unsigned ERR_LIMIT  = 4,
    parameter int unsigned ERR_WINDOW = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] shadow,
    output logic [15:0]      err_count,
    output logic [31:0]      bit_count
);

    localparam int unsigned FILL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);

    lfsr_state_e      state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d, match_inc;
    logic             err_pulse_q, err_pulse_d;
    logic             pred, mismatch, all_ones, win_step, win_clear, limit_hit;

    assign pred      = lfsr_next_bit(32'(shadow_q), TAP_HI, TAP_LO);
    assign mismatch  = (bit_in != pred);
    assign all_ones  = &shadow_q;
    assign match_inc = match_cnt_q + 1'b1;
    assign win_step  = bit_valid && (state_q == ST_LOCKED);

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        err_pulse_d = 1'b0;
        win_clear   = 1'b0;
        if (bit_valid) begin
            unique case (state_q)
                ST_FILL: begin
                    shadow_d = {shadow_q[WIDTH-2:0], bit_in};
                    if (fill_cnt_q == FILL_W'(WIDTH - 1)) begin
                        state_d     = ST_VERIFY;
                        fill_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    // Self-synchronise on the received bit; the lockup state never earns credit.
                    shadow_d = {shadow_q[WIDTH-2:0], bit_in};
                    if (!mismatch && !all_ones) begin
                        if (match_inc == MATCH_W'(LOCK_COUNT)) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_inc;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel on the prediction so a corrupted bit never enters the shadow.
                    shadow_d    = {shadow_q[WIDTH-2:0], pred};
                    err_pulse_d = mismatch;
                    if (limit_hit) begin
                        state_d     = ST_FILL;
                        shadow_d    = '0;
                        fill_cnt_d  = '0;
                        match_cnt_d = '0;
                        win_clear   = 1'b1;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_FILL;
            shadow_q    <= '0;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    lfsr_err_window #(
        .ERR_LIMIT  (ERR_LIMIT),
        .ERR_WINDOW (ERR_WINDOW)
    ) u_err_window (
        .clock       (clock),
        .reset       (reset),
        .step_i      (win_step),
        .mismatch_i  (mismatch),
        .clear_i     (win_clear),
        .limit_hit_o (limit_hit)
    );

`ifdef LFSR_CHK_STATS_EN
    logic [15:0] err_count_q;
    logic [31:0] bit_count_q;

    // Lifetime statistics: survive loss of lock, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count_q <= '0;
            bit_count_q <= '0;
        end else if (win_step) begin
            bit_count_q <= bit_count_q + 1'b1;
            if (mismatch && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 1'b1;
        end
    end

    assign err_count = err_count_q;
    assign bit_count = bit_count_q;
`else
    assign err_count = '0;
    assign bit_count = '0;
`endif

    assign state     = state_q;
    assign shadow    = shadow_q;
    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;

endmodule
